// File: rtl/sisa_pkg.sv
// sCPU instruction-set constants shared by the fetch sequencer and its field decoder.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
// Contents: PC/instruction widths, field bit positions, control opcode and
// condition codes, the 2-bit sequencer state encoding, and the branch-taken rule.
package sisa_pkg;

  localparam int PC_W    = 4;
  localparam int INSTR_W = 8;
  localparam int OP_W    = 2;
  localparam int REG_W   = 2;
  localparam int IMM_W   = 4;

  // Field positions inside the 8-bit instruction word.
  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 4;
  localparam int RS_MSB  = 3;
  localparam int RS_LSB  = 2;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  localparam logic [OP_W-1:0] OP_CTRL = 2'b11;

  // For control ops the rd field carries the condition code.
  localparam logic [REG_W-1:0] COND_JMP  = 2'b00;
  localparam logic [REG_W-1:0] COND_JZ   = 2'b01;
  localparam logic [REG_W-1:0] COND_JNZ  = 2'b10;
  localparam logic [REG_W-1:0] COND_HALT = 2'b11;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  // Whether a jump-class control op loads imm into the PC.
  function automatic logic branch_taken(input logic [REG_W-1:0] cond, input logic zero_flag);
    case (cond)
      COND_JMP: branch_taken = 1'b1;
      COND_JZ:  branch_taken = zero_flag;
      COND_JNZ: branch_taken = ~zero_flag;
      default:  branch_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle between the fetch sequencer, instruction memory and datapath.
// Latency: n/a (wires only).
// Backpressure: stall from the datapath holds the sequencer in EXEC.
// master = sequencer side, slave = memory/datapath side.
// step_req exists only when FETCH_SINGLE_STEP_EN is defined.
interface fetch_sequencer_if;
  import sisa_pkg::*;

  logic [PC_W-1:0]    imem_sel;
  logic [INSTR_W-1:0] imem_instr;
  logic               zero_flag;
  logic               stall;
  logic               restart;
  logic [INSTR_W-1:0] ir;
  logic [OP_W-1:0]    opcode;
  logic [REG_W-1:0]   rd;
  logic [REG_W-1:0]   rs;
  logic [IMM_W-1:0]   imm;
  logic               exec_valid;
  logic               halted;
`ifdef FETCH_SINGLE_STEP_EN
  logic               step_req;
`endif

  modport master (
    output imem_sel, ir, opcode, rd, rs, imm, exec_valid, halted,
`ifdef FETCH_SINGLE_STEP_EN
    input  step_req,
`endif
    input  imem_instr, zero_flag, stall, restart
  );

  modport slave (
    input  imem_sel, ir, opcode, rd, rs, imm, exec_valid, halted,
`ifdef FETCH_SINGLE_STEP_EN
    output step_req,
`endif
    output imem_instr, zero_flag, stall, restart
  );

endinterface

// File: rtl/fetch_sequencer_instr_field_decode.sv
// Splits an instruction word into its fields and flags control ops.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: ir in; opcode/rd/rs/imm slices out; is_ctrl (opcode==OP_CTRL); cond (= rd field).
module instr_field_decode
  import sisa_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output logic [OP_W-1:0]    opcode,
  output logic [REG_W-1:0]   rd,
  output logic [REG_W-1:0]   rs,
  output logic [IMM_W-1:0]   imm,
  output logic               is_ctrl,
  output logic [REG_W-1:0]   cond
);

  assign opcode  = ir[OP_MSB:OP_LSB];
  assign rd      = ir[RD_MSB:RD_LSB];
  assign rs      = ir[RS_MSB:RS_LSB];
  assign imm     = ir[IMM_MSB:IMM_LSB];
  assign is_ctrl = (opcode == OP_CTRL);
  assign cond    = rd;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/exec sequencer for the sCPU: owns PC, latches IR, resolves jumps/halt, strobes exec_valid.
// Latency: 2 cycles per instruction (FETCH, EXEC); exec_valid is registered, high the cycle after EXEC.
// Backpressure: stall holds EXEC (PC, IR, state frozen); restart leaves HALT only.
// Ports: clk, rst_n (async active-low), bus (fetch_sequencer_if.master).
// Optional: FETCH_SINGLE_STEP_EN adds bus.step_req; FETCH then waits for it before latching.
module fetch_sequencer
  import sisa_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 4'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_sequencer_if.master  bus
);

  state_t             state;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir_q;
  logic               exec_valid_q;
  logic               halted_q;

  logic [OP_W-1:0]    dec_opcode;
  logic [REG_W-1:0]   dec_rd;
  logic [REG_W-1:0]   dec_rs;
  logic [IMM_W-1:0]   dec_imm;
  logic               dec_is_ctrl;
  logic [REG_W-1:0]   dec_cond;
  logic               fetch_go;

  instr_field_decode u_decode (
    .ir      (ir_q),
    .opcode  (dec_opcode),
    .rd      (dec_rd),
    .rs      (dec_rs),
    .imm     (dec_imm),
    .is_ctrl (dec_is_ctrl),
    .cond    (dec_cond)
  );

`ifdef FETCH_SINGLE_STEP_EN
  assign fetch_go = bus.step_req;
`else
  assign fetch_go = 1'b1;
`endif

  assign bus.imem_sel   = pc;
  assign bus.ir         = ir_q;
  assign bus.opcode     = dec_opcode;
  assign bus.rd         = dec_rd;
  assign bus.rs         = dec_rs;
  assign bus.imm        = dec_imm;
  assign bus.exec_valid = exec_valid_q;
  assign bus.halted     = halted_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      ir_q         <= '0;
      exec_valid_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      // Strobe defaults low; only a completing datapath op raises it.
      exec_valid_q <= 1'b0;
      case (state)
        FETCH: begin
          if (fetch_go) begin
            ir_q  <= bus.imem_instr;
            state <= EXEC;
          end
        end
        EXEC: begin
          // Stall wins over everything, including branch resolution,
          // so zero_flag is only looked at in the releasing cycle.
          if (!bus.stall) begin
            if (!dec_is_ctrl) begin
              exec_valid_q <= 1'b1;
              pc           <= pc + 4'd1;
              state        <= FETCH;
            end else if (dec_cond == COND_HALT) begin
              halted_q <= 1'b1;
              state    <= HALT;
            end else begin
              pc    <= branch_taken(dec_cond, bus.zero_flag) ? dec_imm : pc + 4'd1;
              state <= FETCH;
            end
          end
        end
        HALT: begin
          if (bus.restart) begin
            pc       <= RESET_PC;
            halted_q <= 1'b0;
            state    <= FETCH;
          end
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule
